// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA timing/pixel path.
// Rebuilds the pixel position from the HS/VS syncs and checks line and frame timing.
// A lock state machine accepts the stream only after clean frames. While locked,
// a rectangular window of each frame is written row-major into a 12-bit frame RAM port.
module vga_capture #(
    parameter int C_H_SYNC_PULSE   = 96,
    parameter int C_H_BACK_PORCH   = 48,
    parameter int C_H_LINE_PERIOD  = 800,
    parameter int C_V_SYNC_PULSE   = 2,
    parameter int C_V_BACK_PORCH   = 33,
    parameter int C_V_FRAME_PERIOD = 525,
    parameter int C_WIN_X          = 256,
    parameter int C_WIN_Y          = 256,
    parameter int C_WIN_W          = 128,
    parameter int C_WIN_H          = 128
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_pix_ce,
    input  logic        I_hs,
    input  logic        I_vs,
    input  logic [3:0]  I_red,
    input  logic [3:0]  I_green,
    input  logic [3:0]  I_blue,
    output logic        O_wr_en,
    output logic [13:0] O_wr_addr,
    output logic [11:0] O_wr_data,
    output logic        O_locked,
    output logic        O_h_err,
    output logic        O_v_err,
    output logic        O_frame_done,
    output logic [11:0] O_line_len
);

    // Window bounds are expressed in the h/v counter space, where 0 is the sync fall.
    localparam logic [11:0] L_H_LO   = 12'(C_H_SYNC_PULSE + C_H_BACK_PORCH + C_WIN_X);
    localparam logic [11:0] L_H_HI   = 12'(C_H_SYNC_PULSE + C_H_BACK_PORCH + C_WIN_X + C_WIN_W - 1);
    localparam logic [11:0] L_V_LO   = 12'(C_V_SYNC_PULSE + C_V_BACK_PORCH + C_WIN_Y);
    localparam logic [11:0] L_V_HI   = 12'(C_V_SYNC_PULSE + C_V_BACK_PORCH + C_WIN_Y + C_WIN_H - 1);
    localparam logic [11:0] L_H_LEN  = 12'(C_H_LINE_PERIOD);
    localparam logic [11:0] L_V_LEN  = 12'(C_V_FRAME_PERIOD);
    localparam logic [11:0] L_V_LEN1 = 12'(C_V_FRAME_PERIOD - 1);
    localparam logic [11:0] L_MAX    = 12'hFFF;
    localparam logic [11:0] L_MAX1   = 12'hFFE;
    localparam logic [13:0] L_LAST   = 14'(C_WIN_W * C_WIN_H - 1);

    typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} t_state;

    t_state      r_state;
    logic        r_good_cnt;
    logic        r_hs_prev;
    logic        r_vs_prev;
    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;
    logic        r_arm;
    logic        r_h_valid;
    logic        r_v_valid;
    logic        r_cap_en;
    logic [13:0] r_addr;

    logic        w_hs_fall;
    logic        w_vs_fall;
    logic        w_frame_start;
    logic [11:0] w_line_len;
    logic [11:0] w_frame_lines;
    logic [11:0] w_h_next;
    logic [11:0] w_v_next;
    logic        w_h_err;
    logic        w_v_err;
    logic        w_err;
    logic        w_in_win;
    logic        w_cap;
    logic        w_wr;
    logic [13:0] w_addr_cur;

    // Position, edge and error decode for the pixel presented on this ce.
    always_comb begin
        w_hs_fall     = r_hs_prev & ~I_hs;
        w_vs_fall     = r_vs_prev & ~I_vs;
        w_frame_start = w_hs_fall & (r_arm | w_vs_fall);
        w_line_len    = r_h_cnt + 12'd1;
        w_frame_lines = r_v_cnt + 12'd1;

        if (w_hs_fall)
            w_h_next = 12'd0;
        else if (r_h_cnt == L_MAX)
            w_h_next = L_MAX;
        else
            w_h_next = r_h_cnt + 12'd1;

        if (w_frame_start)
            w_v_next = 12'd0;
        else if (w_hs_fall && r_v_cnt != L_MAX)
            w_v_next = r_v_cnt + 12'd1;
        else
            w_v_next = r_v_cnt;

        // Saturation is flagged once, on the step into 4095.
        w_h_err = (!w_hs_fall && r_h_cnt == L_MAX1)
               || (w_hs_fall && r_h_valid && w_line_len != L_H_LEN);
        w_v_err = (w_hs_fall && !w_frame_start && r_v_cnt == L_MAX1)
               || (w_frame_start && r_v_valid
                   && w_frame_lines != L_V_LEN && w_frame_lines != L_V_LEN1);
        w_err   = w_h_err | w_v_err;

        w_in_win = (w_h_next >= L_H_LO) && (w_h_next <= L_H_HI)
                && (w_v_next >= L_V_LO) && (w_v_next <= L_V_HI);

        // Capture is decided at frame start from the state the frame began in,
        // and any timing error kills it on the spot.
        if (w_frame_start)
            w_cap = (r_state == ST_LOCKED) && !w_err;
        else
            w_cap = r_cap_en && !w_err;

        w_wr       = w_cap && w_in_win;
        w_addr_cur = w_frame_start ? 14'd0 : r_addr;
    end

    // Sync sampling, h/v counters, line length and error pulses.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_hs_prev  <= 1'b1;
            r_vs_prev  <= 1'b1;
            r_h_cnt    <= 12'd0;
            r_v_cnt    <= 12'd0;
            r_arm      <= 1'b0;
            r_h_valid  <= 1'b0;
            r_v_valid  <= 1'b0;
            O_line_len <= 12'd0;
            O_h_err    <= 1'b0;
            O_v_err    <= 1'b0;
        end else begin
            O_h_err <= 1'b0;
            O_v_err <= 1'b0;
            if (I_pix_ce) begin
                r_hs_prev <= I_hs;
                r_vs_prev <= I_vs;
                r_h_cnt   <= w_h_next;
                r_v_cnt   <= w_v_next;
                O_h_err   <= w_h_err;
                O_v_err   <= w_v_err;
                if (w_hs_fall)
                    O_line_len <= w_line_len;
                // The line after an error is not judged: its start point is unknown.
                if (w_h_err)
                    r_h_valid <= 1'b0;
                else if (w_hs_fall)
                    r_h_valid <= 1'b1;
                if (w_hs_fall && !w_frame_start && r_v_cnt == L_MAX1)
                    r_v_valid <= 1'b0;
                else if (w_frame_start)
                    r_v_valid <= 1'b1;
                if (w_frame_start)
                    r_arm <= 1'b0;
                else if (w_vs_fall)
                    r_arm <= 1'b1;
            end
        end
    end

    // Lock state machine: SEARCH -> VERIFY -> LOCKED after two clean frames.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_state    <= ST_SEARCH;
            r_good_cnt <= 1'b0;
            O_locked   <= 1'b0;
        end else if (I_pix_ce) begin
            if (w_err) begin
                r_state  <= ST_SEARCH;
                O_locked <= 1'b0;
            end else if (w_frame_start) begin
                case (r_state)
                    ST_SEARCH: begin
                        r_state    <= ST_VERIFY;
                        r_good_cnt <= 1'b0;
                    end
                    ST_VERIFY: begin
                        if (r_good_cnt) begin
                            r_state  <= ST_LOCKED;
                            O_locked <= 1'b1;
                        end else begin
                            r_good_cnt <= 1'b1;
                        end
                    end
                    default: begin
                        r_state  <= ST_LOCKED;
                        O_locked <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Window writes: one registered write per window pixel, stopping after the last one.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_cap_en     <= 1'b0;
            r_addr       <= 14'd0;
            O_wr_en      <= 1'b0;
            O_wr_addr    <= 14'd0;
            O_wr_data    <= 12'd0;
            O_frame_done <= 1'b0;
        end else begin
            O_wr_en      <= 1'b0;
            O_frame_done <= 1'b0;
            if (I_pix_ce) begin
                if (w_wr) begin
                    O_wr_en   <= 1'b1;
                    O_wr_addr <= w_addr_cur;
                    O_wr_data <= {I_red, I_green, I_blue};
                    if (w_addr_cur == L_LAST) begin
                        r_addr       <= 14'd0;
                        O_frame_done <= 1'b1;
                        r_cap_en     <= 1'b0;
                    end else begin
                        r_addr   <= w_addr_cur + 14'd1;
                        r_cap_en <= w_cap;
                    end
                end else begin
                    r_addr   <= w_addr_cur;
                    r_cap_en <= w_cap;
                end
            end
        end
    end

endmodule

// File: doc/vga_capture.md
# vga_capture

Receive-side counterpart of the VGA timing/pixel driver. Samples a 640x480@60 VGA stream (active-low HS/VS, 4:4:4 RGB) at pixel rate and reconstructs the horizontal and vertical position. Checks line and frame timing and declares lock. Writes a configurable rectangular window of pixels into a 12-bit-wide frame RAM write port, for loopback self-test and on-board image capture.

## Interface
- C_H_SYNC_PULSE, 96, HS low width in pixels
- C_H_BACK_PORCH, 48, pixels from HS end to first active pixel
- C_H_LINE_PERIOD, 800, expected pixels per line
- C_V_SYNC_PULSE, 2, VS low width in lines
- C_V_BACK_PORCH, 33, lines from VS end to first active line
- C_V_FRAME_PERIOD, 525, expected lines per frame
- C_WIN_X, 256, window left edge, in active-area pixels
- C_WIN_Y, 256, window top edge, in active-area lines
- C_WIN_W, 128, window width
- C_WIN_H, 128, window height; C_WIN_W*C_WIN_H <= 16384
- I_clk  in  1  system clock (100 MHz)
- I_rst  in  1  asynchronous active-high reset
- I_pix_ce  in  1  one-clock pixel strobe, e.g. 1 in 4 clocks for 25 MHz
- I_hs, I_vs  in  1 each  sync inputs, active low
- I_red, I_green, I_blue  in  4 each  colour inputs
- O_wr_en  out  1  frame RAM write strobe, one clock wide
- O_wr_addr  out  14  row-major window address
- O_wr_data  out  12  {red, green, blue}
- O_locked  out  1  timing locked
- O_h_err  out  1  one-clock pulse: bad line length
- O_v_err  out  1  one-clock pulse: bad frame length
- O_frame_done  out  1  one-clock pulse after the last window pixel is written
- O_line_len  out  12  last measured line length in pixels

## Operation
- All inputs are registered on I_pix_ce cycles only. Edges are detected against the previous ce sample.
- **HS fall** (prev 1, now 0):
  - h_cnt is set to 0 and counts +1 per ce after that.
  - Line length is the previous h_cnt+1. It loads O_line_len.
  - If the line length != C_H_LINE_PERIOD, pulse O_h_err. The first HS fall after reset or after an error is exempt.
  - v_cnt increments on each HS fall.
- **VS fall:** sets an arm flag. The next HS fall, or one coincident with the VS fall, starts the frame:
  - v_cnt=0, write address=0, arm cleared.
  - The measured frame line count is checked. It must be within C_V_FRAME_PERIOD or C_V_FRAME_PERIOD-1, otherwise pulse O_v_err.
- **Counter saturation:** h_cnt and v_cnt are 12 bits and saturate at 4095. Reaching 4095 counts as an error: pulse O_h_err or O_v_err, clear lock.
- **Lock state machine:** states SEARCH, VERIFY, LOCKED.
  - SEARCH -> VERIFY on the first frame start.
  - VERIFY -> LOCKED after 2 consecutive complete frames with no error.
  - Any error in VERIFY or LOCKED -> SEARCH.
  - O_locked=1 only in LOCKED.
- **Capture:** active only for frames that begin while LOCKED. A pixel is in the window when both hold:
  - h_cnt in [C_H_SYNC_PULSE+C_H_BACK_PORCH+C_WIN_X, +C_WIN_W-1]
  - v_cnt in [C_V_SYNC_PULSE+C_V_BACK_PORCH+C_WIN_Y, +C_WIN_H-1]
- **Addressing:**
  - Each window pixel gives one write. The address increments after each write.
  - After the write at C_WIN_W*C_WIN_H-1 the address wraps to 0, O_frame_done pulses, and no further writes occur that frame.
- Lock lost mid-frame: writing stops immediately. The address is left as is and reset at the next frame start.

## Timing
- Reset values: O_wr_en=0, O_wr_addr=0, O_wr_data=0, O_locked=0, O_h_err=0, O_v_err=0, O_frame_done=0, O_line_len=0. State is SEARCH, counters and arm flag are 0.
- Write latency:
  - O_wr_en, O_wr_addr and O_wr_data are valid on the clock after the ce on which the pixel was sampled.
  - O_wr_en is high for exactly one clock. Address and data hold until the next write.
- Pulse timing:
  - O_frame_done is asserted on the same clock as the final O_wr_en.
  - Error pulses occur one clock after the detecting ce.
- Coincident HS and VS fall on one ce: frame start takes effect on that line.
- I_pix_ce held low: no state changes. Pulses still deassert after one clock.
- Back-to-back ce (every clock) is supported.

## Test plan
- Ideal 800x525 stream, ce every 4 clocks, pixel = h^v pattern:
  - O_locked rises at the 3rd frame start.
  - The next frame produces 16384 writes, addresses 0..16383.
  - First write data matches the pixel at h=400, v=291.
  - O_frame_done pulses once.
- Stream with 524-line frames: lock is achieved, no O_v_err. With 520-line frames: O_v_err every frame and O_locked stays 0.
- One line of 801 pixels while LOCKED:
  - O_h_err pulses, O_line_len=801, O_locked drops.
  - Writes stop and resume only after relock plus a fresh frame start.
- HS held high for more than 4095 pixels: O_h_err pulses and the state returns to SEARCH.
- I_rst asserted mid-capture: all outputs 0 immediately. After release, relock takes 3 frame starts.
- ce every clock, coincident HS/VS falls: lock and capture behave identically to the first scenario.
